message_tx_seq: RTL
===================

Name: message_tx_seq

Overview:
- Parametrised successor to the single-character message controller.
- On a start request it captures a multi-character message of runtime length, up to MAX_LEN characters.
- Streams the message one character at a time to the UART transmitter over a valid/ready handshake, with an optional programmable inter-character gap, abort and completion reporting.
- Sits between the message source (switch/button logic or host register) and uart_tx.

Parameters:
- DATA_W, 8: character width in bits.
- MAX_LEN, 16: maximum characters per message; must be at least 1.
- LEN_W, $clog2(MAX_LEN+1): width of the length fields.
- GAP_W, 8: width of the inter-character gap count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- send_msg  in  1  start request; sampled only in IDLE.
- abort  in  1  cancels a message in progress.
- msg_len  in  LEN_W  number of characters to send; sampled with send_msg.
- msg_data  in  MAX_LEN*DATA_W  flat message; character 0 in bits [DATA_W-1:0].
- gap_cycles  in  GAP_W  idle cycles inserted after each accepted character; sampled with send_msg.
- tx_data  out  DATA_W  character presented to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the character this cycle.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse: whole message sent.
- aborted  out  1  one-cycle pulse: message cancelled.
- char_idx  out  LEN_W  index of the character currently presented.

Behaviour:
- All outputs are registered.
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0, aborted=0, char_idx=0, state=IDLE. The internal buffer is cleared to 0.
- States:
  - IDLE: send_msg=1 -> LOAD. send_msg is ignored in every other state.
  - LOAD (1 cycle): latch msg_data, gap_cycles and the effective length into internal registers.
    - Effective length = min(msg_len, MAX_LEN).
    - Effective length 0 -> DONE. Otherwise char_idx=0 -> SEND.
  - SEND: tx_valid=1, tx_data=buf[char_idx]. On tx_valid&&tx_ready:
    - Last character (char_idx==len-1) -> DONE.
    - Else gap!=0 -> GAP. Else char_idx+1, stay in SEND with tx_valid held high (back-to-back).
  - GAP: tx_valid=0; count gap cycles from 0. At count==gap-1: char_idx+1 -> SEND.
  - DONE (1 cycle): done=1, buffer cleared, char_idx=0 -> IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid must not change.
  - The only exceptions are abort and rst.
- Latency:
  - send_msg at cycle N: LOAD in N+1, first tx_valid in N+2.
  - With gap=0 and tx_ready tied high, a message of L characters raises done at cycle N+2+L.
  - busy rises at N+1 and falls when the FSM returns to IDLE (cycle after done).
- abort:
  - From LOAD, SEND or GAP: next cycle tx_valid=0, aborted=1 for one cycle, buffer cleared -> IDLE.
  - If abort and the handshake on the last character coincide, the character counts as sent: done wins and aborted is not raised.
  - abort in IDLE or DONE is ignored.
- rst mid-operation: immediate return to reset values; no done or aborted pulse.
- msg_data changing after LOAD has no effect on the message being sent.
- The gap counter is GAP_W wide. gap=2^GAP_W-1 must work without wrap errors.

Decomposition:
- Package message_pkg holds:
  - state encoding localparams: IDLE, LOAD, SEND, GAP, DONE (3-bit);
  - default DATA_W and MAX_LEN constants, shared with uart_tx.
- One sub-module, char_gap_timer: a loadable down-counter with start, a GAP_W count and an expired pulse. It is reusable for uart_tx inter-frame spacing.
- Buffer, index and FSM stay in message_tx_seq.

Test Plan:
- Back-to-back: msg "ABC" (0x41,0x42,0x43), len 3, gap 0, tx_ready=1, send_msg at cycle 0 -> tx_valid cycles 2-4 with data 0x41,0x42,0x43; done at cycle 5; busy cycles 1-5.
- Backpressure: same message, tx_ready low for 3 cycles on 0x42 -> tx_data holds 0x42 with tx_valid high throughout; no character skipped or duplicated; done after the third handshake.
- Gap and zero length: gap 2 -> exactly 2 tx_valid=0 cycles between accepted characters. len 0 -> done at cycle 2 with tx_valid never high.
- Clamp and ignore: len 20 with MAX_LEN=16 -> exactly 16 characters sent. send_msg pulsed during SEND -> ignored, no restart.
- Abort: abort during char 1 of 4 -> tx_valid low next cycle, aborted pulses once, done never asserted. A new send_msg afterwards sends the full message from char 0.
- Reset: rst asserted asynchronously mid-GAP -> all outputs go to reset values without waiting for a clock edge; no done or aborted pulse.

Source files
------------

// File: rtl/message_pkg.sv
// message_pkg: shared character/message sizing defaults and sequencer state encoding
package message_pkg;
  localparam int MSG_DATA_W = 8;
  localparam int MSG_MAX_LEN = 16;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/message_tx_seq_char_gap_timer.sv
// char_gap_timer: loadable down-counter that pulses expired after load_val cycles
module char_gap_timer #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [GAP_W-1:0] load_val,
  output logic             expired
);
  logic [GAP_W-1:0] cnt;
  logic             run;
  assign expired = run && cnt == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= load_val - GAP_W'(1);
      run <= load_val != '0;
    end else if (run) begin
      cnt <= expired ? cnt : cnt - GAP_W'(1);
      run <= !expired;
    end
  end
endmodule

// File: rtl/message_tx_seq.sv
// message_tx_seq: captures a multi-character message and streams it to uart_tx over valid/ready
module message_tx_seq
  import message_pkg::*;
#(
  parameter int DATA_W  = MSG_DATA_W,
  parameter int MAX_LEN = MSG_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int GAP_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      send_msg,
  input  logic                      abort,
  input  logic [LEN_W-1:0]          msg_len,
  input  logic [MAX_LEN*DATA_W-1:0] msg_data,
  input  logic [GAP_W-1:0]          gap_cycles,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic [LEN_W-1:0]          char_idx
);
  localparam int IDX_W = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  state_t                           state, state_d;
  logic [MAX_LEN-1:0][DATA_W-1:0]   mem, mem_d;
  logic [LEN_W-1:0]                 len, len_d, eff_len, idx_d, nxt_idx;
  logic [GAP_W-1:0]                 gap, gap_d;
  logic [DATA_W-1:0]                tx_data_d;
  logic                             tx_valid_d, done_d, aborted_d;
  logic                             hs, last, last_hs, ab, gap_start, gap_expired;
  assign eff_len   = msg_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : msg_len;
  assign hs        = tx_valid && tx_ready;
  assign last      = char_idx == len - LEN_W'(1);
  assign nxt_idx   = char_idx + LEN_W'(1);
  assign last_hs   = state == SEND && hs && last;
  assign ab        = abort && state inside {LOAD, SEND, GAP} && !last_hs;
  assign gap_start = state == SEND && hs && !last && !ab && gap != '0;
  char_gap_timer #(.GAP_W(GAP_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .start    (gap_start),
    .clear    (ab),
    .load_val (gap),
    .expired  (gap_expired)
  );
  always_comb begin
    state_d    = state;
    mem_d      = mem;
    len_d      = len;
    gap_d      = gap;
    idx_d      = char_idx;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    case (state)
      IDLE: state_d = send_msg ? LOAD : IDLE;
      LOAD: begin
        mem_d      = msg_data;
        len_d      = eff_len;
        gap_d      = gap_cycles;
        idx_d      = '0;
        state_d    = eff_len == '0 ? DONE : SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = msg_data[DATA_W-1:0];
      end
      SEND: begin
        if (last_hs) begin
          state_d = DONE;
        end else if (hs) begin
          state_d    = gap != '0 ? GAP : SEND;
          tx_valid_d = gap == '0;
          idx_d      = gap != '0 ? char_idx : nxt_idx;
          tx_data_d  = gap != '0 ? tx_data : mem[nxt_idx[IDX_W-1:0]];
        end
      end
      GAP: begin
        if (gap_expired) begin
          state_d    = SEND;
          tx_valid_d = 1'b1;
          idx_d      = nxt_idx;
          tx_data_d  = mem[nxt_idx[IDX_W-1:0]];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) begin
      done_d     = 1'b1;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      idx_d      = '0;
      mem_d      = '0;
    end
    if (ab) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      aborted_d  = 1'b1;
      tx_valid_d = 1'b0;
      tx_data_d  = '0;
      idx_d      = '0;
      mem_d      = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem      <= '0;
      len      <= '0;
      gap      <= '0;
      char_idx <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_d;
      mem      <= mem_d;
      len      <= len_d;
      gap      <= gap_d;
      char_idx <= idx_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= state_d != IDLE;
      done     <= done_d;
      aborted  <= aborted_d;
    end
  end
endmodule
